// File: rtl/dbus_arbiter.sv
// Two-requester arbiter for the shared data-memory port: latches the winning
// request, holds it on the downstream bus until data_ok, and routes the response back.
module dbus_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_valid,
    input  logic [63:0] r0_addr,
    input  logic [2:0]  r0_size,
    input  logic [7:0]  r0_strobe,
    input  logic [63:0] r0_data,
    output logic        r0_addr_ok,
    output logic        r0_data_ok,
    output logic [63:0] r0_rdata,

    input  logic        r1_valid,
    input  logic [63:0] r1_addr,
    input  logic [2:0]  r1_size,
    input  logic [7:0]  r1_strobe,
    input  logic [63:0] r1_data,
    output logic        r1_addr_ok,
    output logic        r1_data_ok,
    output logic [63:0] r1_rdata,

    output logic        m_valid,
    output logic [63:0] m_addr,
    output logic [2:0]  m_size,
    output logic [7:0]  m_strobe,
    output logic [63:0] m_data,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [63:0] m_rdata,

    output logic [1:0]  grant,
    output logic        err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_reg;
    logic          last_grant_reg;
    logic [CW-1:0] cnt_reg;

    // Requester fields gathered into arrays so the winner can be selected by index.
    logic        req_valid  [2];
    logic [63:0] req_addr   [2];
    logic [2:0]  req_size   [2];
    logic [7:0]  req_strobe [2];
    logic [63:0] req_data   [2];

    logic        rsp_addr_ok [2];
    logic        rsp_data_ok [2];
    logic [63:0] rsp_rdata   [2];

    assign req_valid[0]  = r0_valid;
    assign req_addr[0]   = r0_addr;
    assign req_size[0]   = r0_size;
    assign req_strobe[0] = r0_strobe;
    assign req_data[0]   = r0_data;
    assign req_valid[1]  = r1_valid;
    assign req_addr[1]   = r1_addr;
    assign req_size[1]   = r1_size;
    assign req_strobe[1] = r1_strobe;
    assign req_data[1]   = r1_data;

    // grant is only non-zero while BUSY, so it alone gates the response path.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            assign rsp_addr_ok[gi] = grant[gi] & m_addr_ok;
            assign rsp_data_ok[gi] = grant[gi] & m_data_ok;
            assign rsp_rdata[gi]   = grant[gi] ? m_rdata : 64'd0;
        end
    endgenerate

    assign r0_addr_ok = rsp_addr_ok[0];
    assign r0_data_ok = rsp_data_ok[0];
    assign r0_rdata   = rsp_rdata[0];
    assign r1_addr_ok = rsp_addr_ok[1];
    assign r1_data_ok = rsp_data_ok[1];
    assign r1_rdata   = rsp_rdata[1];

    logic win_any;
    logic win_idx;

    always_comb begin
        win_any = req_valid[0] | req_valid[1];
        win_idx = 1'b0;
        if (req_valid[0] && req_valid[1]) begin
            win_idx = (ROUND_ROBIN != 0) ? ~last_grant_reg : 1'b0;
        end else if (req_valid[1]) begin
            win_idx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            m_valid        <= 1'b0;
            m_addr         <= 64'd0;
            m_size         <= 3'd0;
            m_strobe       <= 8'd0;
            m_data         <= 64'd0;
            grant          <= 2'b00;
            err            <= 1'b0;
            last_grant_reg <= 1'b1;
            cnt_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_any) begin
                        state_reg <= BUSY;
                        m_valid   <= 1'b1;
                        m_addr    <= req_addr[win_idx];
                        m_size    <= req_size[win_idx];
                        m_strobe  <= req_strobe[win_idx];
                        m_data    <= req_data[win_idx];
                        grant     <= win_idx ? 2'b10 : 2'b01;
                        cnt_reg   <= '0;
                    end
                end
                BUSY: begin
                    if (m_data_ok) begin
                        state_reg      <= IDLE;
                        m_valid        <= 1'b0;
                        m_addr         <= 64'd0;
                        m_size         <= 3'd0;
                        m_strobe       <= 8'd0;
                        m_data         <= 64'd0;
                        grant          <= 2'b00;
                        last_grant_reg <= grant[1];
                    end else if (cnt_reg != TMAX) begin
                        // Counter saturates at TIMEOUT; err is sticky until reset.
                        cnt_reg <= cnt_reg + CW'(1);
                        if ((TIMEOUT != 0) && ((cnt_reg + CW'(1)) == TMAX)) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: a round-robin/TIMEOUT=4 instance and a fixed-priority/no-timeout
// instance share stimulus and are checked every cycle against a transaction-level model.
module tb_dbus_arbiter;

    logic        clk;
    logic        reset;
    logic        r0_valid, r1_valid;
    logic [63:0] r0_addr, r1_addr, r0_data, r1_data;
    logic [2:0]  r0_size, r1_size;
    logic [7:0]  r0_strobe, r1_strobe;
    logic        m_addr_ok, m_data_ok;
    logic [63:0] m_rdata;

    logic        o_m_valid [2];
    logic [63:0] o_m_addr  [2];
    logic [2:0]  o_m_size  [2];
    logic [7:0]  o_m_strobe[2];
    logic [63:0] o_m_data  [2];
    logic [1:0]  o_grant   [2];
    logic        o_err     [2];
    logic        o_r0_aok  [2];
    logic        o_r0_dok  [2];
    logic [63:0] o_r0_rdata[2];
    logic        o_r1_aok  [2];
    logic        o_r1_dok  [2];
    logic [63:0] o_r1_rdata[2];

    int vectors = 0;
    int miscompares = 0;

    dbus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(4)) u_rr (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_size(r0_size), .r0_strobe(r0_strobe),
        .r0_data(r0_data), .r0_addr_ok(o_r0_aok[0]), .r0_data_ok(o_r0_dok[0]), .r0_rdata(o_r0_rdata[0]),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_size(r1_size), .r1_strobe(r1_strobe),
        .r1_data(r1_data), .r1_addr_ok(o_r1_aok[0]), .r1_data_ok(o_r1_dok[0]), .r1_rdata(o_r1_rdata[0]),
        .m_valid(o_m_valid[0]), .m_addr(o_m_addr[0]), .m_size(o_m_size[0]), .m_strobe(o_m_strobe[0]),
        .m_data(o_m_data[0]), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .grant(o_grant[0]), .err(o_err[0])
    );

    dbus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(0)) u_fp (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_size(r0_size), .r0_strobe(r0_strobe),
        .r0_data(r0_data), .r0_addr_ok(o_r0_aok[1]), .r0_data_ok(o_r0_dok[1]), .r0_rdata(o_r0_rdata[1]),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_size(r1_size), .r1_strobe(r1_strobe),
        .r1_data(r1_data), .r1_addr_ok(o_r1_aok[1]), .r1_data_ok(o_r1_dok[1]), .r1_rdata(o_r1_rdata[1]),
        .m_valid(o_m_valid[1]), .m_addr(o_m_addr[1]), .m_size(o_m_size[1]), .m_strobe(o_m_strobe[1]),
        .m_data(o_m_data[1]), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .grant(o_grant[1]), .err(o_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner is -1 when no transaction is outstanding.
    int          own  [2];
    int          age  [2];
    int          last [2];
    bit          merr [2];
    logic [63:0] l_addr[2], l_data[2];
    logic [2:0]  l_size[2];
    logic [7:0]  l_strb[2];

    function automatic int cfg_rr(int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic int cfg_to(int d);
        return (d == 0) ? 4 : 0;
    endfunction

    task automatic model_update();
        int w;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                own[d] = -1; age[d] = 0; merr[d] = 0; last[d] = 1;
            end else if (own[d] < 0) begin
                if (r0_valid && r1_valid) w = (cfg_rr(d) != 0) ? 1 - last[d] : 0;
                else if (r0_valid)        w = 0;
                else if (r1_valid)        w = 1;
                else                      w = -1;
                if (w >= 0) begin
                    own[d]    = w;
                    age[d]    = 0;
                    l_addr[d] = (w == 0) ? r0_addr : r1_addr;
                    l_size[d] = (w == 0) ? r0_size : r1_size;
                    l_strb[d] = (w == 0) ? r0_strobe : r1_strobe;
                    l_data[d] = (w == 0) ? r0_data : r1_data;
                end
            end else if (m_data_ok) begin
                last[d] = own[d];
                own[d]  = -1;
            end else begin
                age[d]++;
                if (cfg_to(d) != 0 && age[d] >= cfg_to(d)) merr[d] = 1;
            end
        end
    endtask

    task automatic cmp(string name, int d, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[dut%0d] t=%0t: got %h, expected %h", name, d, $time, act, exp);
        end
    endtask

    task automatic check_all();
        bit b;
        for (int d = 0; d < 2; d++) begin
            b = own[d] >= 0;
            cmp("m_valid", d, 64'(o_m_valid[d]), 64'(b));
            cmp("m_addr", d, o_m_addr[d], b ? l_addr[d] : 64'd0);
            cmp("m_size", d, 64'(o_m_size[d]), b ? 64'(l_size[d]) : 64'd0);
            cmp("m_strobe", d, 64'(o_m_strobe[d]), b ? 64'(l_strb[d]) : 64'd0);
            cmp("m_data", d, o_m_data[d], b ? l_data[d] : 64'd0);
            cmp("grant", d, 64'(o_grant[d]), !b ? 64'd0 : (own[d] == 0 ? 64'd1 : 64'd2));
            cmp("err", d, 64'(o_err[d]), 64'(merr[d]));
            cmp("r0_addr_ok", d, 64'(o_r0_aok[d]), 64'(own[d] == 0 && m_addr_ok));
            cmp("r0_data_ok", d, 64'(o_r0_dok[d]), 64'(own[d] == 0 && m_data_ok));
            cmp("r0_rdata", d, o_r0_rdata[d], (own[d] == 0) ? m_rdata : 64'd0);
            cmp("r1_addr_ok", d, 64'(o_r1_aok[d]), 64'(own[d] == 1 && m_addr_ok));
            cmp("r1_data_ok", d, 64'(o_r1_dok[d]), 64'(own[d] == 1 && m_data_ok));
            cmp("r1_rdata", d, o_r1_rdata[d], (own[d] == 1) ? m_rdata : 64'd0);
        end
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        bit          rst, v0, v1, aok, dok;
        logic [63:0] rdata;
        bit          e_mvalid;
        logic [1:0]  e_grant;
        bit          e_r0_dok, e_r1_dok;
        logic [63:0] e_r0_rdata;
        bit          e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rst, bit v0, bit v1, bit aok, bit dok, logic [63:0] rd,
                                bit mv, logic [1:0] g, bit d0, bit d1, logic [63:0] rd0, bit e);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.v1 = v1; v.aok = aok; v.dok = dok; v.rdata = rd;
        v.e_mvalid = mv; v.e_grant = g; v.e_r0_dok = d0; v.e_r1_dok = d1;
        v.e_r0_rdata = rd0; v.e_err = e;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [63:0] rd;
        int w;

        reset = 1'b1; r0_valid = 0; r1_valid = 0;
        r0_addr = 64'h80001008; r0_size = 3'd3; r0_strobe = 8'h00; r0_data = 64'd0;
        r1_addr = 64'h2000; r1_size = 3'd3; r1_strobe = 8'hff; r1_data = 64'habc;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 64'd0;
        repeat (2) begin
            @(posedge clk);
            model_update();
        end
        #1;

        // Single read on r0, then round-robin ties (fixed-priority instance follows the model).
        add(0, 1, 0, 0, 0, 64'd0, 0, 2'b00, 0, 0, 64'd0, 0);
        add(0, 0, 0, 0, 0, 64'd0, 1, 2'b01, 0, 0, 64'd0, 0);
        add(0, 0, 0, 0, 0, 64'd0, 1, 2'b01, 0, 0, 64'd0, 0);
        add(0, 0, 0, 0, 0, 64'd0, 1, 2'b01, 0, 0, 64'd0, 0);
        add(0, 0, 0, 1, 1, 64'h1122334455667788, 1, 2'b01, 1, 0, 64'h1122334455667788, 0);
        add(0, 0, 0, 0, 0, 64'd0, 0, 2'b00, 0, 0, 64'd0, 0);
        add(1, 1, 1, 0, 0, 64'd0, 0, 2'b00, 0, 0, 64'd0, 0);
        for (int k = 0; k < 4; k++) begin
            w  = k % 2;
            rd = 64'h10 * (k + 1);
            add(0, 1, 1, 0, 0, 64'd0, 0, 2'b00, 0, 0, 64'd0, 0);
            add(0, 1, 1, 0, 0, 64'd0, 1, (w == 0) ? 2'b01 : 2'b10, 0, 0, 64'd0, 0);
            add(0, 1, 1, 1, 1, rd, 1, (w == 0) ? 2'b01 : 2'b10, w == 0, w == 1,
                (w == 0) ? rd : 64'd0, 0);
        end
        add(0, 0, 0, 0, 0, 64'd0, 0, 2'b00, 0, 0, 64'd0, 0);

        reset = 1'b0;
        foreach (tbl[i]) begin
            reset = tbl[i].rst; r0_valid = tbl[i].v0; r1_valid = tbl[i].v1;
            m_addr_ok = tbl[i].aok; m_data_ok = tbl[i].dok; m_rdata = tbl[i].rdata;
            settle();
            cmp("tbl_m_valid", 0, 64'(o_m_valid[0]), 64'(tbl[i].e_mvalid));
            cmp("tbl_grant", 0, 64'(o_grant[0]), 64'(tbl[i].e_grant));
            cmp("tbl_r0_data_ok", 0, 64'(o_r0_dok[0]), 64'(tbl[i].e_r0_dok));
            cmp("tbl_r1_data_ok", 0, 64'(o_r1_dok[0]), 64'(tbl[i].e_r1_dok));
            cmp("tbl_r0_rdata", 0, o_r0_rdata[0], tbl[i].e_r0_rdata);
            cmp("tbl_err", 0, 64'(o_err[0]), 64'(tbl[i].e_err));
            advance();
        end
        reset = 1'b0; r0_valid = 0; r1_valid = 0; m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;

        // Stability: r1 write whose request fields change while BUSY.
        r1_valid = 1; r1_addr = 64'h1000; r1_size = 3'd2; r1_strobe = 8'h0f; r1_data = 64'hdeadbeef;
        settle(); advance();
        r1_addr = 64'h2222; r1_data = 64'h5555; r1_strobe = 8'hf0; m_addr_ok = 1;
        settle();
        for (int d = 0; d < 2; d++) begin
            cmp("stab_addr", d, o_m_addr[d], 64'h1000);
            cmp("stab_strobe", d, 64'(o_m_strobe[d]), 64'h0f);
            cmp("stab_r1_addr_ok", d, 64'(o_r1_aok[d]), 64'd1);
            cmp("stab_r1_data_ok_early", d, 64'(o_r1_dok[d]), 64'd0);
        end
        advance();
        m_addr_ok = 0;
        settle();
        for (int d = 0; d < 2; d++) cmp("stab_addr2", d, o_m_addr[d], 64'h1000);
        advance();
        m_data_ok = 1; r1_valid = 0;
        settle();
        for (int d = 0; d < 2; d++) begin
            cmp("stab_data", d, o_m_data[d], 64'hdeadbeef);
            cmp("stab_r1_data_ok", d, 64'(o_r1_dok[d]), 64'd1);
            cmp("stab_r0_data_ok", d, 64'(o_r0_dok[d]), 64'd0);
        end
        advance();
        m_data_ok = 0;
        settle();
        for (int d = 0; d < 2; d++) cmp("stab_idle_valid", d, 64'(o_m_valid[d]), 64'd0);
        advance();

        // Timeout: data_ok withheld for 10 BUSY cycles.
        r0_valid = 1;
        settle(); advance();
        r0_valid = 0;
        for (int i = 1; i <= 10; i++) begin
            settle();
            cmp("to_err", 0, 64'(o_err[0]), 64'(i >= 5));
            cmp("to_err_disabled", 1, 64'(o_err[1]), 64'd0);
            advance();
        end
        m_data_ok = 1;
        settle(); advance();
        m_data_ok = 0;
        settle();
        cmp("to_err_sticky", 0, 64'(o_err[0]), 64'd1);
        advance();
        reset = 1;
        settle(); advance();
        reset = 0;
        settle();
        cmp("to_err_cleared", 0, 64'(o_err[0]), 64'd0);
        cmp("to_grant_cleared", 0, 64'(o_grant[0]), 64'd0);
        advance();

        // Reset mid-BUSY, then a stray data_ok while IDLE.
        r0_valid = 1;
        settle(); advance();
        r0_valid = 0;
        settle(); advance();
        reset = 1;
        settle();
        for (int d = 0; d < 2; d++) cmp("rst_busy_valid", d, 64'(o_m_valid[d]), 64'd1);
        advance();
        reset = 0;
        settle();
        for (int d = 0; d < 2; d++) cmp("rst_after_valid", d, 64'(o_m_valid[d]), 64'd0);
        advance();
        m_data_ok = 1; m_addr_ok = 1; m_rdata = 64'h99;
        settle();
        for (int d = 0; d < 2; d++) begin
            cmp("stray_r0_data_ok", d, 64'(o_r0_dok[d]), 64'd0);
            cmp("stray_r1_data_ok", d, 64'(o_r1_dok[d]), 64'd0);
        end
        advance();
        m_data_ok = 0; m_addr_ok = 0;
        settle();
        for (int d = 0; d < 2; d++) cmp("stray_grant", d, 64'(o_grant[d]), 64'd0);
        advance();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(63) == 0);
            r0_valid  = $urandom_range(1);
            r1_valid  = $urandom_range(1);
            r0_addr   = {$urandom, $urandom};
            r1_addr   = {$urandom, $urandom};
            r0_size   = 3'($urandom_range(3));
            r1_size   = 3'($urandom_range(3));
            r0_strobe = 8'($urandom);
            r1_strobe = 8'($urandom);
            r0_data   = {$urandom, $urandom};
            r1_data   = {$urandom, $urandom};
            m_addr_ok = ($urandom_range(2) == 0);
            m_data_ok = ($urandom_range(3) == 0);
            m_rdata   = {$urandom, $urandom};
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
